// File: rtl/mips_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: widths, op codes and FSM states.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ITER   = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_NOP0  = 3'b110,
    OP_NOP1  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  // Two's-complement magnitude; 0x80000000 stays 0x80000000, which is correct read as unsigned.
  function automatic logic [DATA_W-1:0] absVal(input logic [DATA_W-1:0] v, input logic isSigned);
    return (isSigned && v[DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide on magnitudes.
module muldiv_step
  import mips_pkg::*;
(
  input  logic              isDiv,
  input  logic [DATA_W-1:0] accHi,
  input  logic [DATA_W-1:0] accLo,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] nextHi,
  output logic [DATA_W-1:0] nextLo
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] shifted;
  logic            noSub;

  // The partial remainder is always below the divisor, so the subtract result fits in DATA_W bits.
  always_comb begin
    sum     = {1'b0, accHi} + {1'b0, (accLo[0] ? operand : '0)};
    shifted = {accHi, accLo[DATA_W-1]};
    noSub   = shifted < {1'b0, operand};
    nextHi  = '0;
    nextLo  = '0;
    if (isDiv) begin
      if (noSub) begin
        nextHi = shifted[DATA_W-1:0];
        nextLo = {accLo[DATA_W-2:0], 1'b0};
      end else begin
        nextHi = shifted[DATA_W-1:0] - operand;
        nextLo = {accLo[DATA_W-2:0], 1'b1};
      end
    end else begin
      nextHi = sum[DATA_W:1];
      nextLo = {sum[0], accLo[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: 32 cycles per MULT/DIV, single-cycle MTHI/MTLO.
module muldiv_unit
  import mips_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] rs_i,
  input  logic [DATA_W-1:0] rt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  state_e              state, nextState;
  op_e                 opCode;
  logic [5:0]          iterCount;
  logic [DATA_W-1:0]   accHi, accLo, operand;
  logic [DATA_W-1:0]   stepHi, stepLo;
  logic [DATA_W-1:0]   rsMag, rtMag, resultHi, resultLo, quot, rem;
  logic [2*DATA_W-1:0] product;
  logic                isDiv, negMain, negRem;
  logic                signedOp, lastIter;

  muldiv_step u_step (
    .isDiv   (isDiv),
    .accHi   (accHi),
    .accLo   (accLo),
    .operand (operand),
    .nextHi  (stepHi),
    .nextLo  (stepLo)
  );

  always_comb begin
    opCode   = op_e'(op_i);
    signedOp = ~op_i[0];
    rsMag    = absVal(rs_i, signedOp);
    rtMag    = absVal(rt_i, signedOp);
    lastIter = (iterCount == 6'(ITER - 1));
  end

  // Sign correction is applied to the final step's output so HI/LO load in the same edge.
  always_comb begin
    product  = {stepHi, stepLo};
    if (negMain) product = ~product + 1'b1;
    quot     = negMain ? (~stepLo + 1'b1) : stepLo;
    rem      = negRem ? (~stepHi + 1'b1) : stepHi;
    resultHi = isDiv ? rem  : product[2*DATA_W-1:DATA_W];
    resultLo = isDiv ? quot : product[DATA_W-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        done_o    = (state == ST_DONE);
        nextState = (start_i && !op_i[2]) ? ST_BUSY : ST_IDLE;
      end
      ST_BUSY: begin
        busy_o = 1'b1;
        if (lastIter) nextState = ST_DONE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  // Divide-by-zero keeps the quotient unsigned all-ones, and the remainder sign fix restores rs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      iterCount <= '0;
      accHi     <= '0;
      accLo     <= '0;
      operand   <= '0;
      isDiv     <= 1'b0;
      negMain   <= 1'b0;
      negRem    <= 1'b0;
      hi_o      <= '0;
      lo_o      <= '0;
    end else if (state == ST_BUSY) begin
      accHi     <= stepHi;
      accLo     <= stepLo;
      iterCount <= iterCount + 6'd1;
      if (lastIter) begin
        hi_o <= resultHi;
        lo_o <= resultLo;
      end
    end else if (start_i) begin
      case (opCode)
        OP_MTHI: hi_o <= rs_i;
        OP_MTLO: lo_o <= rs_i;
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
          iterCount <= '0;
          accHi     <= '0;
          isDiv     <= op_i[1];
          operand   <= op_i[1] ? rtMag : rsMag;
          accLo     <= op_i[1] ? rsMag : rtMag;
          negMain   <= signedOp & (rs_i[DATA_W-1] ^ rt_i[DATA_W-1]) & (|rt_i);
          negRem    <= signedOp & op_i[1] & rs_i[DATA_W-1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model checked every cycle plus literal vectors.
module tb_muldiv_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        busy, done;
  logic [31:0] hi, lo;

  int testsRun    = 0;
  int testsFailed = 0;

  int          remaining = 0;
  logic        mDone     = 1'b0;
  logic [31:0] mHi       = '0;
  logic [31:0] mLo       = '0;
  logic [63:0] pendRes   = '0;
  logic        sawDone;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .op_i    (op),
    .rs_i    (rs),
    .rt_i    (rt),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  // Reference result {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] expectedResult(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = '0;
    case (o)
      3'b000: res = 64'(sa * sb);
      3'b001: res = {32'b0, a} * {32'b0, b};
      3'b010: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {32'(r), 32'(q)};
        end
      end
      3'b011: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else            res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Model: ops are accepted only when no result is pending; results land 32 edges later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= 0;
      mDone     <= 1'b0;
      mHi       <= '0;
      mLo       <= '0;
    end else begin
      mDone <= 1'b0;
      if (remaining > 0) begin
        remaining <= remaining - 1;
        if (remaining == 1) begin
          mHi   <= pendRes[63:32];
          mLo   <= pendRes[31:0];
          mDone <= 1'b1;
        end
      end else if (start) begin
        case (op)
          3'b100: mHi <= rs;
          3'b101: mLo <= rs;
          3'b000, 3'b001, 3'b010, 3'b011: begin
            pendRes   <= expectedResult(op, rs, rt);
            remaining <= 32;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model_busy", {31'b0, busy}, {31'b0, (remaining > 0)});
    checkOutput("model_done", {31'b0, done}, {31'b0, mDone});
    checkOutput("model_hi", hi, mHi);
    checkOutput("model_lo", lo, mLo);
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Drive one request for a single edge, then scramble operands to expose missing latching.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    @(posedge clk);
    #2;
    start = 1'b0;
    op    = 3'b111;
    rs    = 32'hDEADBEEF;
    rt    = 32'h0BADF00D;
  endtask

  task automatic runArith(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
    applyStimulus(o, a, b);
    waitCycles(31);
    checkOutput({name, "_busy"}, {31'b0, busy}, 32'd1);
    waitCycles(1);
    checkOutput({name, "_done"}, {31'b0, done}, 32'd1);
    checkOutput({name, "_hi"}, hi, eh);
    checkOutput({name, "_lo"}, lo, el);
    waitCycles(1);
    checkOutput({name, "_done_end"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    start = 1'b0;
    op    = 3'b111;
    rs    = '0;
    rt    = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    #1;
    rst = 1'b0;

    applyStimulus(3'b101, 32'h13572468, 32'd0);
    checkOutput("mtlo_first_edge", lo, 32'h13572468);
    checkOutput("mtlo_no_busy", {31'b0, busy}, 32'd0);
    applyStimulus(3'b100, 32'h2468ACE0, 32'd0);
    checkOutput("mthi_write", hi, 32'h2468ACE0);
    checkOutput("mthi_no_done", {31'b0, done}, 32'd0);

    runArith("mult_neg1x2",  3'b000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE);
    runArith("multu_max_x2", 3'b001, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE);
    runArith("mult_mixed",   3'b000, 32'h00012345, 32'hFFFF0000, 32'hFFFFFFFE, 32'hDCBB0000);
    runArith("div_m7_2",     3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runArith("div_7_m2",     3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    runArith("divu_100_7",   3'b011, 32'd100,      32'd7,        32'd2,        32'd14);
    runArith("divu_by_zero", 3'b011, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF);
    runArith("div_by_zero",  3'b010, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF);
    runArith("div_overflow", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    applyStimulus(3'b110, 32'h11111111, 32'h22222222);
    checkOutput("nop_no_busy", {31'b0, busy}, 32'd0);
    checkOutput("nop_hi_hold", hi, 32'h00000000);

    // MTHI during BUSY is dropped, then a new op is accepted straight out of DONE.
    applyStimulus(3'b000, 32'd3, 32'd5);
    waitCycles(4);
    applyStimulus(3'b100, 32'hA5A5A5A5, 32'd0);
    checkOutput("mthi_in_busy_hi", hi, 32'h00000000);
    checkOutput("mthi_in_busy_busy", {31'b0, busy}, 32'd1);
    waitCycles(27);
    checkOutput("collide_done", {31'b0, done}, 32'd1);
    checkOutput("collide_hi", hi, 32'd0);
    checkOutput("collide_lo", lo, 32'd15);
    applyStimulus(3'b011, 32'd1000, 32'd3);
    checkOutput("b2b_busy", {31'b0, busy}, 32'd1);
    checkOutput("b2b_hi_hold", hi, 32'd0);
    waitCycles(32);
    checkOutput("b2b_done", {31'b0, done}, 32'd1);
    checkOutput("b2b_hi", hi, 32'd1);
    checkOutput("b2b_lo", lo, 32'd333);
    waitCycles(1);

    applyStimulus(3'b000, 32'h12345678, 32'h9ABCDEF0);
    waitCycles(9);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_mid_done", {31'b0, done}, 32'd0);
    checkOutput("rst_mid_hi", hi, 32'd0);
    checkOutput("rst_mid_lo", lo, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checkOutput("rst_no_done", {31'b0, sawDone}, 32'd0);
    checkOutput("rst_hi_stays", hi, 32'd0);
    @(posedge clk);
    #2;
    runArith("post_reset_mult", 3'b000, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
